// File: rtl/riscv_pkg.sv
// Shared encodings for the MEM-stage load/store unit: funct3 codes,
// the LSU state type, byte-enable patterns and the alignment helper.
package riscv_pkg;

    // Load funct3 encodings; stores reuse the low two bits as the size
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Access size field funct3[1:0]; anything else behaves as a word
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;

    localparam logic [3:0] BE_BYTE    = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } lsu_state_t;

    // Halfwords need addr[0]=0, words (and unused sizes) need addr[1:0]=0
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic mis;
        case (f3[1:0])
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = off[0];
            default: mis = (off != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load alignment: picks the addressed byte/half out of the
// read word and sign- or zero-extends it according to funct3.
module lsu_load_align
    import riscv_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Lane select, then extend; unused funct3 values fall through as LW
    always_comb begin
        case (off_i)
            2'd0:    byte_v = rdata_i[7:0];
            2'd1:    byte_v = rdata_i[15:8];
            2'd2:    byte_v = rdata_i[23:16];
            default: byte_v = rdata_i[31:24];
        endcase
        half_v = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (funct3_i)
            F3_LB:   data_o = {{24{byte_v[7]}}, byte_v};
            F3_LH:   data_o = {{16{half_v[15]}}, half_v};
            F3_LBU:  data_o = {24'h0, byte_v};
            F3_LHU:  data_o = {16'h0, half_v};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit with the MEM/WB pipeline register.
//
//   state | meaning
//   ------+---------------------------------------------------------
//   IDLE  | no access outstanding; aligned mem op requests and stalls
//   WAIT  | dmem_req held stable until ack or timeout abort
module mem_stage_lsu
    import riscv_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mem_valid,
    input  logic            memread,
    input  logic            memwrite,
    input  logic            memtoreg,
    input  logic            regwrite,
    input  logic [4:0]      rd,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] store_data,
    output logic            stall,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [3:0]      dmem_be,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_ack,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            wb_valid,
    output logic            wb_memtoreg,
    output logic            wb_regwrite,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_read_data,
    output logic [XLEN-1:0] wb_result,
    output logic            misalign,
    output logic            bus_err
);

    localparam int CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int LAST_INT = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [CNT_W-1:0] CNT_LAST = LAST_INT[CNT_W-1:0];

    lsu_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic        mem_op;
    logic        misal;
    logic        misal_fault;
    logic        acc_start;
    logic        acc_done;
    logic        acc_abort;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic [31:0] load_data;

    assign mem_op      = mem_valid & (memread | memwrite);
    assign misal       = is_misaligned(funct3, alu_result[1:0]);
    assign misal_fault = (state_q == IDLE) & mem_op & misal;

    // Next state, wait counter and stall; ack wins over a same-cycle timeout
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stall     = 1'b0;
        acc_start = 1'b0;
        acc_done  = 1'b0;
        acc_abort = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_op && !misal) begin
                    stall     = 1'b1;
                    acc_start = 1'b1;
                    cnt_d     = '0;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                if (dmem_ack) begin
                    acc_done = 1'b1;
                    state_d  = IDLE;
                end else if ((TIMEOUT_CYCLES > 0) && (cnt_q == CNT_LAST)) begin
                    acc_abort = 1'b1;
                    state_d   = IDLE;
                end else begin
                    stall = 1'b1;
                    if (TIMEOUT_CYCLES > 0) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state and wait counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Store lane enables and per-lane replicated write data
    always_comb begin
        case (funct3[1:0])
            SZ_BYTE: begin
                be_d    = BE_BYTE << alu_result[1:0];
                wdata_d = {4{store_data[7:0]}};
            end
            SZ_HALF: begin
                be_d    = alu_result[1] ? BE_HALF_HI : BE_HALF_LO;
                wdata_d = {2{store_data[15:0]}};
            end
            default: begin
                be_d    = BE_WORD;
                wdata_d = store_data;
            end
        endcase
    end

    // Memory request register: loaded on entry to WAIT, dropped on ack/abort
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_be    <= 4'h0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
        end else if (acc_start) begin
            dmem_req   <= 1'b1;
            dmem_we    <= memwrite;
            dmem_be    <= be_d;
            dmem_addr  <= {alu_result[31:2], 2'b00};
            dmem_wdata <= wdata_d;
        end else if (acc_done || acc_abort) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            dmem_be  <= 4'h0;
        end
    end

    lsu_load_align u_align (
        .rdata_i  (dmem_rdata),
        .off_i    (alu_result[1:0]),
        .funct3_i (funct3),
        .data_o   (load_data)
    );

    // MEM/WB register: bubble while stalled, otherwise retire the slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid     <= 1'b0;
            wb_memtoreg  <= 1'b0;
            wb_regwrite  <= 1'b0;
            wb_rd        <= 5'd0;
            wb_read_data <= '0;
            wb_result    <= '0;
            misalign     <= 1'b0;
            bus_err      <= 1'b0;
        end else if (stall) begin
            wb_valid    <= 1'b0;
            wb_regwrite <= 1'b0;
            misalign    <= 1'b0;
            bus_err     <= 1'b0;
        end else begin
            wb_valid     <= mem_valid;
            wb_memtoreg  <= memtoreg;
            wb_regwrite  <= mem_valid & regwrite & ~misal_fault & ~acc_abort;
            wb_rd        <= rd;
            wb_result    <= alu_result;
            wb_read_data <= (acc_done && !memwrite) ? load_data : '0;
            misalign     <= misal_fault;
            bus_err      <= acc_abort;
        end
    end

endmodule
